uart_rx_fifo: RTL

//  Parametrised UART receiver for the SoC IO subsystem: runtime baud divisor, DATA_BITS-wide frames,

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// FIFO read-side bus of the UART receiver.
// slave = receiver/FIFO, master = bus-side register block.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
);
    logic                   rd_en;
    logic [DATA_BITS-1:0]   rd_data;
    logic                   rd_frame_err;
    logic                   rd_parity_err;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overrun;
    logic                   clr_overrun;

    modport master (
        output rd_en, clr_overrun,
        input  rd_data, rd_frame_err, rd_parity_err,
        input  empty, full, count, overrun
    );

    modport slave (
        input  rd_en, clr_overrun,
        output rd_data, rd_frame_err, rd_parity_err,
        output empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority vote, error flags and FWFT FIFO.
// Define UART_RX_PARITY_EN to enable the parity bit and rd_parity_err.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rx,
    uart_rx_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_RX_PARITY_EN
    localparam int EW = DATA_BITS + 2;
`else
    localparam int EW = DATA_BITS + 1;
`endif
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [3:0]       NBITS = 4'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic                 prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     div_q, div_d;
    logic [1:0]           smp_q, smp_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 push_q, push_d;
    logic [EW-1:0]        entry_q, entry_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_act_q, par_act_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
`else
    logic                 unused_cfg;
    assign unused_cfg = parity_en ^ parity_odd;
`endif

    logic [EW-1:0]        mem_q [DEPTH];
    logic [EW-1:0]        mem_d [DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovr_q, ovr_d;

    logic                 rx_s, fall, last, decide, bit_v;
    logic                 empty, full, do_push, do_pop;
    logic [CNT_W-1:0]     half;

    assign rx_s   = sync_q[1];
    assign fall   = prev_q & ~rx_s;
    assign half   = div_q >> 1;
    assign last   = (cnt_q == div_q - ONE);
    assign decide = (cnt_q == half + ONE);
    assign bit_v  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) |
                    (smp_q[1] & rx_s);

    // Receive FSM: bit timing, majority sampling, frame assembly.
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx};
        prev_d  = rx_s;
        cnt_d   = '0;
        div_d   = div_q;
        smp_d   = smp_q;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        push_d  = 1'b0;
        entry_d = entry_q;
`ifdef UART_RX_PARITY_EN
        par_act_d = par_act_q;
        par_odd_d = par_odd_q;
        perr_d    = perr_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = last ? '0 : cnt_q + ONE;
            if (cnt_q == half - ONE) smp_d[0] = rx_s;
            if (cnt_q == half)       smp_d[1] = rx_s;
        end
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    div_d   = baud_div;
                    bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_act_d = parity_en;
                    par_odd_d = parity_odd;
                    perr_d    = 1'b0;
`endif
                end
            end
            START: begin
                if (decide && bit_v) state_d = IDLE;
                else if (last)       state_d = DATA;
            end
            DATA: begin
                if (decide) begin
                    data_d = {bit_v, data_q[DATA_BITS-1:1]};
                    bcnt_d = bcnt_q + 4'd1;
                end
                if (last && bcnt_q == NBITS) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_act_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) perr_d = bit_v != (^data_q ^ par_odd_q);
                if (last)   state_d = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    push_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    entry_d = {perr_q, ~bit_v, data_q};
`else
                    entry_d = {~bit_v, data_q};
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = bus.rd_en & ~empty;
    assign do_push = push_q & (~full | do_pop);

    // FIFO pointers, occupancy and sticky overrun (set beats clear).
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (do_push) begin
            mem_d[wptr_q] = entry_q;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        if (bus.clr_overrun)  ovr_d = 1'b0;
        if (push_q && !do_push) ovr_d = 1'b1;
    end

    // State registers; async reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            div_q   <= '0;
            smp_q   <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            push_q  <= 1'b0;
            entry_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_act_q <= 1'b0;
            par_odd_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            push_q  <= push_d;
            entry_q <= entry_d;
`ifdef UART_RX_PARITY_EN
            par_act_q <= par_act_d;
            par_odd_q <= par_odd_d;
            perr_q    <= perr_d;
`endif
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.rd_data      = mem_q[rptr_q][DATA_BITS-1:0];
    assign bus.rd_frame_err = mem_q[rptr_q][DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign bus.rd_parity_err = mem_q[rptr_q][DATA_BITS+1];
`else
    assign bus.rd_parity_err = 1'b0;
`endif
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.overrun = ovr_q;
endmodule
